// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 teaching pipeline: opcode values and the
// hazard controller state encoding.
package mips32_pkg;

  localparam logic [5:0] OP_ADD    = 6'd0;
  localparam logic [5:0] OP_SUB    = 6'd1;
  localparam logic [5:0] OP_MUL    = 6'd2;
  localparam logic [5:0] OP_DIV    = 6'd3;
  localparam logic [5:0] OP_ADDI   = 6'd4;
  localparam logic [5:0] OP_SUBI   = 6'd5;
  localparam logic [5:0] OP_LOAD   = 6'd6;
  localparam logic [5:0] OP_STORE  = 6'd7;
  localparam logic [5:0] OP_BRANCH = 6'd8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_BR_WAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } hz_state_e;

  function automatic logic [5:0] ir_opcode(input logic [31:0] ir);
    return ir[31:26];
  endfunction

endpackage

// File: rtl/instr_classify.sv
// Decodes which register fields an ID-stage instruction reads and which one
// (if any) it writes.
module instr_classify
  import mips32_pkg::*;
(
  input  logic [31:0] id_ir,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        has_dest,
  output logic [4:0]  dest
);

  // Immediate/offset bits never take part in hazard detection.
  logic unused_imm;
  assign unused_imm = ^id_ir[10:0];

  always_comb begin
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    has_dest = 1'b0;
    dest     = 5'd0;
    case (ir_opcode(id_ir))
      OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
        has_dest = 1'b1;
        dest     = id_ir[15:11];
      end
      OP_ADDI, OP_SUBI, OP_LOAD: begin
        uses_rs  = 1'b1;
        has_dest = 1'b1;
        dest     = id_ir[20:16];
      end
      OP_STORE, OP_BRANCH: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Scoreboard-based RAW/WAW interlock and branch-resolution controller for the
// ID stage, with stall and issue performance counters.
module pipe_hazard_ctrl
  import mips32_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_ir,
  input  logic             wb_valid,
  input  logic [4:0]       wb_dest,
  input  logic             ex_br_valid,
  input  logic             ex_br_taken,
  output logic             issue,
  output logic             stall,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  hz_state_e   state_q, state_d;
  logic [31:0] sb_q, sb_d;
  logic        uses_rs, uses_rt, has_dest;
  logic [4:0]  dest;
  logic        hazard;
  logic        is_branch;

  instr_classify u_classify (
    .id_ir    (id_ir),
    .uses_rs  (uses_rs),
    .uses_rt  (uses_rt),
    .has_dest (has_dest),
    .dest     (dest)
  );

  // Registered scoreboard only: a writeback in this same cycle does not unblock.
  assign hazard = (uses_rs  && sb_q[id_ir[25:21]]) ||
                  (uses_rt  && sb_q[id_ir[20:16]]) ||
                  (has_dest && sb_q[dest]);

  assign is_branch = (ir_opcode(id_ir) == OP_BRANCH);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: begin
        state_d = ST_RUN;
        if (id_valid) begin
          if (hazard) begin
            stall   = 1'b1;
            state_d = ST_STALL;
          end else begin
            issue   = 1'b1;
            state_d = is_branch ? ST_BR_WAIT : ST_RUN;
          end
        end
      end
      ST_BR_WAIT: begin
        stall = 1'b1;
        if (ex_br_valid) begin
          state_d = ex_br_taken ? ST_FLUSH : ST_RUN;
        end
      end
      ST_FLUSH: begin
        flush   = 1'b1;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (!rst_n) begin
      issue = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
    end
  end

  // Issue sets after the WB clear so a new writer always wins its bit.
  always_comb begin
    sb_d = sb_q;
    if (wb_valid) begin
      sb_d[wb_dest] = 1'b0;
    end
    if (issue && has_dest) begin
      sb_d[dest] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      sb_q      <= 32'd0;
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (issue) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

endmodule
